// File: rtl/uart_rx_deframer.sv
// uart_rx_deframer: 16550-style serial receive engine, start/data/parity/stop recovery.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority bit decisions at cnt 6/7/8.
module uart_rx_deframer #(
   parameter int OVS         = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       baud_pulse,
   input  logic       rx,
   input  logic [1:0] wls,
   input  logic       pen,
   input  logic       eps,
   input  logic       sticky_par,
   output logic [7:0] rx_data,
   output logic       rx_push,
   output logic       pe,
   output logic       fe,
   output logic       bi,
   output logic       rx_busy
);
   localparam int CW = $clog2(OVS);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   state_t                 r_state, w_state_nx;
   logic [SYNC_STAGES-1:0] r_sync, r_vld;
   logic                   r_rx_prev, r_arm;
   logic [CW-1:0]          r_cnt;
   logic [2:0]             r_idx;
   logic [7:0]             r_sh;
   logic [1:0]             r_wls;
   logic                   r_pen, r_eps, r_stk, r_pe_acc, r_zero;
   logic [7:0]             r_data;
   logic                   r_push, r_pe, r_fe, r_bi;
   logic                   w_rxs, w_fall, w_sp, w_bit, w_exp;
   logic                   w_accept, w_shift, w_pchk, w_fin;
   logic [7:0]             w_data;

   assign w_rxs  = r_sync[SYNC_STAGES-1];
   // r_arm blocks the preset-high synchronizer from faking an edge when the line is low out of reset
   assign w_fall = r_arm & r_rx_prev & ~w_rxs;
   assign w_data = r_sh >> (2'd3 - r_wls);
   assign w_exp  = r_stk ? ~r_eps : (r_eps ? ^w_data : ~^w_data);

`ifdef UART_RX_MAJORITY_EN
   logic r_s6, r_s7;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s6 <= 1'b1;
         r_s7 <= 1'b1;
      end else begin
         if (baud_pulse && r_cnt == CW'(OVS/2-2)) r_s6 <= w_rxs;
         if (baud_pulse && r_cnt == CW'(OVS/2-1)) r_s7 <= w_rxs;
      end
   end
   assign w_sp  = baud_pulse && r_cnt == CW'(OVS/2);
   assign w_bit = (r_s6 & r_s7) | (r_s6 & w_rxs) | (r_s7 & w_rxs);
`else
   assign w_sp  = baud_pulse && r_cnt == CW'(OVS/2-1);
   assign w_bit = w_rxs;
`endif

   always_comb begin
      w_state_nx = r_state;
      w_accept   = 1'b0;
      w_shift    = 1'b0;
      w_pchk     = 1'b0;
      w_fin      = 1'b0;
      case (r_state)
         IDLE:   if (w_fall) w_state_nx = START;
         START:  if (w_sp) begin
            w_accept   = ~w_bit;
            w_state_nx = w_bit ? IDLE : DATA;
         end
         DATA:   if (w_sp) begin
            w_shift = 1'b1;
            if (r_idx == {1'b1, r_wls}) w_state_nx = r_pen ? PARITY : STOP;
         end
         PARITY: if (w_sp) begin
            w_pchk     = 1'b1;
            w_state_nx = STOP;
         end
         STOP:   if (w_sp) begin
            w_fin      = 1'b1;
            w_state_nx = IDLE;
         end
         default: w_state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= IDLE;
         r_sync    <= '1;
         r_vld     <= '0;
         r_rx_prev <= 1'b1;
         r_arm     <= 1'b0;
         r_cnt     <= '0;
         r_idx     <= '0;
         r_sh      <= '0;
         r_wls     <= '0;
         r_pen     <= 1'b0;
         r_eps     <= 1'b0;
         r_stk     <= 1'b0;
         r_pe_acc  <= 1'b0;
         r_zero    <= 1'b0;
         r_data    <= '0;
         r_push    <= 1'b0;
         r_pe      <= 1'b0;
         r_fe      <= 1'b0;
         r_bi      <= 1'b0;
      end else begin
         r_sync    <= {r_sync[SYNC_STAGES-2:0], rx};
         r_vld     <= {r_vld[SYNC_STAGES-2:0], 1'b1};
         r_rx_prev <= w_rxs;
         r_arm     <= r_arm | (r_vld[SYNC_STAGES-1] & w_rxs);
         r_state   <= w_state_nx;
         r_cnt     <= (r_state == IDLE && w_fall) ? '0 : r_cnt + CW'(baud_pulse);
         r_push    <= w_fin;
         if (w_accept) begin
            r_wls    <= wls;
            r_pen    <= pen;
            r_eps    <= eps;
            r_stk    <= sticky_par;
            r_idx    <= '0;
            r_sh     <= '0;
            r_pe_acc <= 1'b0;
            r_zero   <= 1'b1;
         end
         if (w_shift) begin
            r_sh   <= {w_bit, r_sh[7:1]};
            r_idx  <= r_idx + 3'd1;
            r_zero <= r_zero & ~w_bit;
         end
         if (w_pchk) begin
            r_pe_acc <= w_bit != w_exp;
            r_zero   <= r_zero & ~w_bit;
         end
         if (w_fin) begin
            r_data <= w_data;
            r_pe   <= r_pe_acc;
            r_fe   <= ~w_bit;
            r_bi   <= r_zero & ~w_bit;
         end
      end
   end

   assign rx_data = r_data;
   assign rx_push = r_push;
   assign pe      = r_pe;
   assign fe      = r_fe;
   assign bi      = r_bi;
   assign rx_busy = r_state != IDLE;
endmodule

// File: doc/uart_rx_deframer.md
Name: uart_rx_deframer

Overview:
- 16550-compatible serial receive engine; the line-side counterpart of the UART transmitter.
- Consumes the asynchronous rx line and the 16x baud tick from the register/baud block.
- Recovers start/data/parity/stop framing and pushes one character plus error flags per frame into the downstream RX FIFO/LSR logic.

Parameters:
- OVS, 16, baud_pulse ticks per bit period (power of two).
- SYNC_STAGES, 2, flops in the rx input synchronizer (minimum 2).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- baud_pulse  in  1  one-clk-wide 16x oversample tick
- rx  in  1  serial line, asynchronous to clk, idle high
- wls  in  2  word length select: 00=5, 01=6, 10=7, 11=8 bits
- pen  in  1  parity enable
- eps  in  1  even parity select (1=even, 0=odd)
- sticky_par  in  1  stick parity: expected parity bit = ~eps
- rx_data  out  8  received character, right-aligned, unused upper bits 0
- rx_push  out  1  one-clk strobe: rx_data/pe/fe/bi valid
- pe  out  1  parity error for pushed character
- fe  out  1  framing error (stop sample = 0)
- bi  out  1  break indication (data, parity and stop all 0)
- rx_busy  out  1  high whenever state != IDLE

Behaviour:
- Reset: all outputs 0, state IDLE, tick counter 0, synchronizer flops preset to 1, rx_prev = 1.
- rx is passed through SYNC_STAGES flops; all logic uses the synced value rxs (SYNC_STAGES clk latency).
- Tick counter cnt (4 bits) increments only on baud_pulse and wraps 15 -> 0. "Sample point" = baud_pulse && cnt==7.
- IDLE: on falling edge of rxs (rx_prev=1, rxs=0), clear cnt and go to START. A line held low out of reset never starts a frame.
- START: at sample point, if rxs==1 it is a false start -> IDLE with no push. Otherwise latch wls/pen/eps/sticky_par for the whole frame, clear bit index, go to DATA. Config changes mid-frame are ignored.
- DATA: at each sample point, shift the sample in LSB-first. After 5+wls bits go to PARITY if pen, else STOP.
- PARITY: at sample point, compare against expected:
  - sticky_par=1: expected = ~eps.
  - else eps=1 (even): expected = ^data; eps=0 (odd): expected = ~^data.
  - Mismatch sets the pe flag; then go to STOP.
- STOP: at sample point (mid stop bit):
  - fe = ~rxs.
  - bi = 1 iff all data bits, the parity bit (if enabled) and the stop bit sampled 0.
  - rx_data updated and rx_push=1 for exactly one clk on the following clock edge.
  - Go to IDLE immediately: half-stop resynchronisation; a second stop bit is not checked.
- Back-to-back frames: a falling edge occurring after the stop mid-sample is accepted as a new start.
- After a break, no new frame starts until rxs returns high and falls again.
- pe/fe/bi/rx_data hold their values until the next push. rx_push is never asserted two consecutive cycles.
- baud_pulse outside the sample point only advances cnt. No baud_pulse means no state progress.
- Reset mid-frame: immediate return to reset values; partial character discarded, no push.

Optional Feature:
- Macro UART_RX_MAJORITY_EN.
- When defined: each bit (start, data, parity, stop) is decided by a 2-of-3 majority of rxs at cnt 6, 7 and 8. The decision and all state transitions move to baud_pulse && cnt==8, so rx_push occurs one tick later than the undefined case. The start-bit check also uses the majority.
- When undefined: single sample at cnt==7 as described under Behaviour.

Test Plan:
- Frame, no parity: wls=11, pen=0, baud_pulse every 4 clk, send 0x45 (start, LSB-first, stop=1) -> one rx_push, rx_data=0x45, pe=fe=bi=0.
- Odd parity: wls=11, pen=1, eps=0, send 0x45 with parity bit 0 -> rx_data=0x45, pe=0. Repeat with parity bit 1 -> pe=1.
- Short word and stick parity: wls=00, pen=1, sticky_par=1, eps=1, send 5'b10110 with parity bit 0 -> rx_data=0x16, pe=0.
- Errors: stop bit 0 with data 0x3C -> fe=1, bi=0. All-zero frame including parity and stop -> bi=1, fe=1. No new frame until rx goes high and falls.
- Glitch and false start: rx low for 4 ticks then high -> no push, rx_busy returns to 0. Reset asserted mid-DATA -> no push, outputs 0. The next clean 0xA5 frame is received correctly.
- UART_RX_MAJORITY_EN: 0x55 frame with a one-tick inverted glitch at cnt 6 of bit 3 -> rx_data=0x55 with macro defined. Without the macro, the same stimulus with the glitch at cnt 7 yields 0x5D.
